uart_rx: RTL and testbench

Simplex UART receiver: the receive-side counterpart of the team's FPGA-master UART transmitter.
- Samples an asynchronous serial line (8N1, LSB first, idle high) at mid-bit.
- Validates start and stop bits and pushes good bytes into a circular receive buffer.
- Presents buffered bytes to on-chip logic through a valid/ready handshake.
- Sits between the board RX pin (e.g. from the FT232R) and the command/pixel consumer logic.

---
 rtl/uart_rx.sv | 184 ++++++++++++++++++
 tb/tb_uart_rx.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with mid-bit sampling, start/stop validation
// and a circular receive buffer drained through a valid/ready handshake.
// Optional build macro: UART_RX_PARITY_EN (8E1 framing, adds o_parity_error).
module uart_rx #(
  parameter int ClockFrequency = 50_000_000,
  parameter int BaudRate       = 115200,
  parameter int BufferSize     = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       i_data,
  input  logic       i_ready,
  output logic [7:0] o_frame,
  output logic       o_valid,
  output logic       o_framing_error,
  output logic       o_overrun
`ifdef UART_RX_PARITY_EN
  ,
  output logic       o_parity_error
`endif
);

  localparam int TicksPerBit = ClockFrequency / BaudRate;
  localparam int TickW       = $clog2(TicksPerBit);
  localparam int PtrW        = $clog2(BufferSize);
  localparam logic [TickW-1:0] TickLast = TickW'(TicksPerBit - 1);
  localparam logic [TickW-1:0] TickMid  = TickW'(TicksPerBit / 2 - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd3,
                            PARITY = 3'd4} state_t;
`else
  typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd3} state_t;
`endif

  state_t           state;
  logic             sync1;
  logic             rxs;
  logic [TickW-1:0] tick;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic [PtrW-1:0]  head;
  logic [PtrW-1:0]  tail;
  logic [PtrW-1:0]  head_next;
  logic [7:0]       mem [BufferSize];
  logic             full;
  logic             stop_ok;
  logic             par_bad;
  logic             push;
  logic             pop;
`ifdef UART_RX_PARITY_EN
  logic             par;
`endif

  assign o_valid = (head != tail);
  assign o_frame = o_valid ? mem[tail] : 8'h00;

  // Buffer status and push/pop decisions, all from pre-edge state.
  always_comb begin
    head_next = head + PtrW'(1);
    full      = (head_next == tail);
    stop_ok   = (state == STOP) && (tick == TickLast) && rxs;
`ifdef UART_RX_PARITY_EN
    par_bad   = ^{shreg, par};
`else
    par_bad   = 1'b0;
`endif
    push      = stop_ok && !par_bad && !full;
    pop       = o_valid && i_ready;
  end

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= i_data;
      rxs   <= sync1;
    end
  end

  // Frame FSM: start detect, mid-bit sampling, stop check and error pulses.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state           <= IDLE;
      tick            <= '0;
      bit_cnt         <= 3'd0;
      shreg           <= 8'h00;
      o_framing_error <= 1'b0;
      o_overrun       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par             <= 1'b0;
      o_parity_error  <= 1'b0;
`endif
    end else begin
      o_framing_error <= 1'b0;
      o_overrun       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      o_parity_error  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          tick <= '0;
          if (!rxs) state <= START;
        end
        START: begin
          if (tick == TickMid) begin
            tick    <= '0;
            bit_cnt <= 3'd0;
            state   <= rxs ? IDLE : DATA;
          end else begin
            tick <= tick + TickW'(1);
          end
        end
        DATA: begin
          if (tick == TickLast) begin
            tick    <= '0;
            shreg   <= {rxs, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            tick <= tick + TickW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick == TickLast) begin
            tick  <= '0;
            par   <= rxs;
            state <= STOP;
          end else begin
            tick <= tick + TickW'(1);
          end
        end
`endif
        STOP: begin
          if (tick == TickLast) begin
            tick  <= '0;
            state <= IDLE;
            if (!rxs) begin
              o_framing_error <= 1'b1;
            end else if (par_bad) begin
`ifdef UART_RX_PARITY_EN
              o_parity_error <= 1'b1;
`endif
            end else if (full) begin
              o_overrun <= 1'b1;
            end
          end else begin
            tick <= tick + TickW'(1);
          end
        end
        default: begin
          state <= IDLE;
          tick  <= '0;
        end
      endcase
    end
  end

  // Circular buffer pointers; full test above uses pre-edge pointers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (push) head <= head_next;
      if (pop)  tail <= tail + PtrW'(1);
    end
  end

  // Buffer storage; contents are only meaningful between tail and head.
  always_ff @(posedge CLK) begin
    if (push) mem[head] <= shreg;
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx at 20 clocks per bit.
module tb_uart_rx;
  localparam int T = 20;

  logic       CLK = 1'b0;
  logic       RST;
  logic       i_data;
  logic       i_ready;
  logic [7:0] o_frame;
  logic       o_valid;
  logic       o_framing_error;
  logic       o_overrun;
`ifdef UART_RX_PARITY_EN
  logic       o_parity_error;
  logic       force_bad_par = 1'b0;
  int         pe_cnt = 0;
`endif

  int checks = 0;
  int errors = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int valid_cnt = 0;
  logic [7:0] pop_q [$];

  int fe0, ov0, vc0, q0;

  uart_rx #(.ClockFrequency(2_000_000), .BaudRate(100_000), .BufferSize(16)) dut (
    .CLK(CLK), .RST(RST), .i_data(i_data), .i_ready(i_ready),
    .o_frame(o_frame), .o_valid(o_valid),
    .o_framing_error(o_framing_error), .o_overrun(o_overrun)
`ifdef UART_RX_PARITY_EN
    , .o_parity_error(o_parity_error)
`endif
  );

  always #5 CLK = ~CLK;

  // Observe pulses and accepted bytes midway between clock edges.
  always @(negedge CLK) begin
    if (!RST) begin
      if (o_framing_error) fe_cnt++;
      if (o_overrun) ov_cnt++;
      if (o_valid) valid_cnt++;
      if (o_valid && i_ready) pop_q.push_back(o_frame);
`ifdef UART_RX_PARITY_EN
      if (o_parity_error) pe_cnt++;
`endif
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic bit_period(input logic v);
    i_data = v;
    cycles(T);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    bit_period(1'b0);
    for (int i = 0; i < 8; i++) bit_period(b[i]);
`ifdef UART_RX_PARITY_EN
    bit_period((^b) ^ force_bad_par);
`endif
    bit_period(stop_bit);
    i_data = 1'b1;
  endtask

  task automatic pop_one();
    i_ready = 1'b1;
    cycles(1);
    i_ready = 1'b0;
  endtask

  task automatic snap();
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    vc0 = valid_cnt;
    q0  = pop_q.size();
  endtask

  initial begin
    RST = 1'b1;
    i_data = 1'b1;
    i_ready = 1'b0;
    #1;
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_frame", 32'(o_frame), 32'h00);
    check("rst_fe", 32'(o_framing_error), 32'd0);
    check("rst_ov", 32'(o_overrun), 32'd0);
    cycles(3);
    RST = 1'b0;
    cycles(10);

    // Single byte 0x55 with consumer always ready
    i_ready = 1'b1;
    snap();
    send_frame(8'h55, 1'b1);
    cycles(10);
    check("b55_count", 32'(pop_q.size() - q0), 32'd1);
    check("b55_data", 32'(pop_q[q0]), 32'h55);
    check("b55_valid_cycles", 32'(valid_cnt - vc0), 32'd1);
    check("b55_fe", 32'(fe_cnt - fe0), 32'd0);
    check("b55_ov", 32'(ov_cnt - ov0), 32'd0);
    check("b55_empty", 32'(o_valid), 32'd0);

    // Back-to-back 0x00, 0xFF held in buffer, then popped in order
    i_ready = 1'b0;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    cycles(5);
    check("b2b_valid", 32'(o_valid), 32'd1);
    check("b2b_first", 32'(o_frame), 32'h00);
    pop_one();
    check("b2b_second", 32'(o_frame), 32'hFF);
    check("b2b_valid2", 32'(o_valid), 32'd1);
    pop_one();
    check("b2b_drained", 32'(o_valid), 32'd0);
    check("b2b_frame_zero", 32'(o_frame), 32'h00);

    // Short low glitch: shorter than half a bit, must be ignored
    snap();
    i_data = 1'b0;
    cycles(4);
    i_data = 1'b1;
    cycles(40);
    check("glitch_valid", 32'(o_valid), 32'd0);
    check("glitch_fe", 32'(fe_cnt - fe0), 32'd0);
    check("glitch_ov", 32'(ov_cnt - ov0), 32'd0);

    // Framing error: 0xA3 with stop bit low
    snap();
    send_frame(8'hA3, 1'b0);
    cycles(30);
    check("fe_pulse_cycles", 32'(fe_cnt - fe0), 32'd1);
    check("fe_no_push", 32'(o_valid), 32'd0);
    check("fe_ov", 32'(ov_cnt - ov0), 32'd0);

    // Fill: 0x01..0x10, capacity 15, overrun on 0x10
    snap();
    for (int i = 1; i <= 16; i++) begin
      send_frame(8'(i), 1'b1);
      if (i == 15) check("fill_no_ov_yet", 32'(ov_cnt - ov0), 32'd0);
    end
    cycles(5);
    check("fill_ov_pulse", 32'(ov_cnt - ov0), 32'd1);
    check("fill_fe", 32'(fe_cnt - fe0), 32'd0);
    check("fill_head", 32'(o_frame), 32'h01);
    i_ready = 1'b1;
    cycles(20);
    i_ready = 1'b0;
    check("fill_pop_count", 32'(pop_q.size() - q0), 32'd15);
    for (int i = 0; i < 15; i++) check("fill_pop_data", 32'(pop_q[q0 + i]), 32'(i + 1));
    check("fill_drained", 32'(o_valid), 32'd0);
    snap();
    i_ready = 1'b1;
    send_frame(8'h42, 1'b1);
    cycles(10);
    i_ready = 1'b0;
    check("wrap_count", 32'(pop_q.size() - q0), 32'd1);
    check("wrap_data", 32'(pop_q[q0]), 32'h42);

    // Reset mid-frame during bit 4 of 0x5A with one byte pending
    send_frame(8'h77, 1'b1);
    cycles(5);
    check("pre_rst_valid", 32'(o_valid), 32'd1);
    bit_period(1'b0);
    for (int i = 0; i < 4; i++) bit_period(1'(8'h5A >> i));
    i_data = 1'b1;
    cycles(T / 2);
    RST = 1'b1;
    #1;
    check("midrst_valid", 32'(o_valid), 32'd0);
    check("midrst_frame", 32'(o_frame), 32'h00);
    check("midrst_fe", 32'(o_framing_error), 32'd0);
    check("midrst_ov", 32'(o_overrun), 32'd0);
    cycles(1);
    RST = 1'b0;
    i_data = 1'b1;
    cycles(30);
    check("postrst_idle", 32'(o_valid), 32'd0);
    snap();
    i_ready = 1'b1;
    send_frame(8'h3C, 1'b1);
    cycles(10);
    i_ready = 1'b0;
    check("postrst_count", 32'(pop_q.size() - q0), 32'd1);
    check("postrst_data", 32'(pop_q[q0]), 32'h3C);
    check("postrst_fe", 32'(fe_cnt - fe0), 32'd0);

`ifdef UART_RX_PARITY_EN
    // 0x3C has even weight, so parity bit 1 is wrong
    snap();
    begin
      int pe0;
      pe0 = pe_cnt;
      force_bad_par = 1'b1;
      send_frame(8'h3C, 1'b1);
      force_bad_par = 1'b0;
      cycles(10);
      check("par_pulse", 32'(pe_cnt - pe0), 32'd1);
      check("par_no_push", 32'(o_valid), 32'd0);
      check("par_fe", 32'(fe_cnt - fe0), 32'd0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
